// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: per-channel period/duty/phase/burst with
// double-buffered configuration that takes effect at the period wrap point.
module pwm_multi_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_50M_o,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [7:0]        cfg_burst,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r  [NUM_CH];
    state_t             state_s  [NUM_CH];
    logic [CNT_W-1:0]   per_r    [NUM_CH];
    logic [CNT_W-1:0]   per_s    [NUM_CH];
    logic [CNT_W-1:0]   duty_r   [NUM_CH];
    logic [CNT_W-1:0]   duty_s   [NUM_CH];
    logic [7:0]         burst_r  [NUM_CH];
    logic [7:0]         burst_s  [NUM_CH];
    logic [CNT_W-1:0]   cnt_r    [NUM_CH];
    logic [CNT_W-1:0]   cnt_s    [NUM_CH];
    logic [7:0]         bc_r     [NUM_CH];
    logic [7:0]         bc_s     [NUM_CH];
    logic [7:0]         bc_inc_s [NUM_CH];
    logic [CNT_W-1:0]   pper_r   [NUM_CH];
    logic [CNT_W-1:0]   pper_s   [NUM_CH];
    logic [CNT_W-1:0]   pduty_r  [NUM_CH];
    logic [CNT_W-1:0]   pduty_s  [NUM_CH];
    logic [7:0]         pburst_r [NUM_CH];
    logic [7:0]         pburst_s [NUM_CH];
    logic [NUM_CH-1:0]  pend_v_r;
    logic [NUM_CH-1:0]  pend_v_s;
    logic [NUM_CH-1:0]  hit_s;
    logic [NUM_CH-1:0]  wrap_s;
    logic [NUM_CH-1:0]  pwm_s;
    logic [NUM_CH-1:0]  busy_s;
    logic [NUM_CH-1:0]  done_s;
    logic               wr_ok_s;

    assign wr_ok_s = cfg_we && ({1'b0, cfg_ch} < 5'(NUM_CH)) && (cfg_period != CNT_ZERO);

    // Per-channel write decode, wrap detect and saturating completed-period count
    always_comb begin
        hit_s  = {NUM_CH{1'b0}};
        wrap_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            hit_s[i]    = wr_ok_s && (cfg_ch == 4'(i));
            wrap_s[i]   = (cnt_r[i] == per_r[i]);
            bc_inc_s[i] = (bc_r[i] == 8'hFF) ? 8'hFF : (bc_r[i] + 8'd1);
        end
    end

    // Channel FSM next state: wrap actions use pre-write registers, the write is layered on top
    always_comb begin
        state_s  = state_r;
        per_s    = per_r;
        duty_s   = duty_r;
        burst_s  = burst_r;
        cnt_s    = cnt_r;
        bc_s     = bc_r;
        pper_s   = pper_r;
        pduty_s  = pduty_r;
        pburst_s = pburst_r;
        pend_v_s = pend_v_r;
        pwm_s    = {NUM_CH{1'b0}};
        busy_s   = {NUM_CH{1'b0}};
        done_s   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_s[i] = (state_r[i] != ST_IDLE) && (cnt_r[i] < duty_r[i]);
            case (state_r[i])
                ST_IDLE: begin
                    cnt_s[i] = CNT_ZERO;
                    bc_s[i]  = 8'd0;
                    if (hit_s[i] && cfg_en) begin
                        per_s[i]    = cfg_period;
                        duty_s[i]   = cfg_duty;
                        burst_s[i]  = cfg_burst;
                        cnt_s[i]    = (cfg_phase > cfg_period) ? CNT_ZERO : cfg_phase;
                        pend_v_s[i] = 1'b0;
                        state_s[i]  = ST_RUN;
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (wrap_s[i]) begin
                        cnt_s[i] = CNT_ZERO;
                        if (state_r[i] == ST_STOP) begin
                            state_s[i] = ST_IDLE;
                            bc_s[i]    = 8'd0;
                            done_s[i]  = 1'b1;
                        end else if ((burst_r[i] != 8'd0) && (bc_inc_s[i] == burst_r[i])) begin
                            state_s[i] = ST_IDLE;
                            bc_s[i]    = 8'd0;
                            done_s[i]  = 1'b1;
                        end else if (pend_v_r[i]) begin
                            per_s[i]    = pper_r[i];
                            duty_s[i]   = pduty_r[i];
                            burst_s[i]  = pburst_r[i];
                            pend_v_s[i] = 1'b0;
                            bc_s[i]     = 8'd0;
                        end else begin
                            bc_s[i] = bc_inc_s[i];
                        end
                    end else begin
                        cnt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                    if (hit_s[i] && cfg_en) begin
                        pper_s[i]   = cfg_period;
                        pduty_s[i]  = cfg_duty;
                        pburst_s[i] = cfg_burst;
                        pend_v_s[i] = 1'b1;
                        // A channel ending this very edge stays idle; the write just parks in pending
                        state_s[i]  = (state_s[i] == ST_IDLE) ? ST_IDLE : ST_RUN;
                    end else if (hit_s[i] && (state_s[i] == ST_RUN)) begin
                        state_s[i] = ST_STOP;
                    end else begin
                        state_s[i] = state_s[i];
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    cnt_s[i]   = CNT_ZERO;
                    bc_s[i]    = 8'd0;
                end
            endcase
            busy_s[i] = (state_s[i] != ST_IDLE);
        end
    end

    // State, configuration and output registers
    always_ff @(posedge clk_50M_o or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]  <= ST_IDLE;
                per_r[i]    <= CNT_ZERO;
                duty_r[i]   <= CNT_ZERO;
                burst_r[i]  <= 8'd0;
                cnt_r[i]    <= CNT_ZERO;
                bc_r[i]     <= 8'd0;
                pper_r[i]   <= CNT_ZERO;
                pduty_r[i]  <= CNT_ZERO;
                pburst_r[i] <= 8'd0;
            end
            pend_v_r <= {NUM_CH{1'b0}};
            pwm_out  <= {NUM_CH{1'b0}};
            busy     <= {NUM_CH{1'b0}};
            done     <= {NUM_CH{1'b0}};
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]  <= state_s[i];
                per_r[i]    <= per_s[i];
                duty_r[i]   <= duty_s[i];
                burst_r[i]  <= burst_s[i];
                cnt_r[i]    <= cnt_s[i];
                bc_r[i]     <= bc_s[i];
                pper_r[i]   <= pper_s[i];
                pduty_r[i]  <= pduty_s[i];
                pburst_r[i] <= pburst_s[i];
            end
            pend_v_r <= pend_v_s;
            pwm_out  <= pwm_s;
            busy     <= busy_s;
            done     <= done_s;
            cfg_ack  <= wr_ok_s;
            cfg_err  <= cfg_we && !wr_ok_s;
        end
    end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Parametrised multi-channel PWM generator clocked from `clk_50M_o`. It replaces the fixed divide-by-50 toggle counter that drives the slow PWM port. Each channel has a programmable period, duty, start phase and burst count. Configuration writes are double-buffered and take effect glitch-free at a period boundary. Outputs feed the OBUF/ODDR pin stage in the top level.

## Interface
- NUM_CH, 4, number of independent PWM channels (1..16)
- CNT_W, 16, width of period/duty/phase counters
- clk_50M_o  in  1  50 MHz generator clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  single-cycle configuration write strobe
- cfg_ch  in  4  target channel index
- cfg_en  in  1  1 = run channel, 0 = request stop
- cfg_period  in  CNT_W  terminal count P; period = P+1 cycles, P ≥ 1
- cfg_duty  in  CNT_W  high cycles per period D; D=0 gives constant low, D>P gives constant high
- cfg_phase  in  CNT_W  counter start value at start-up (reduced: phase>P loads 0)
- cfg_burst  in  8  periods to emit; 0 = continuous
- cfg_ack  out  1  one-cycle pulse: write accepted
- cfg_err  out  1  one-cycle pulse: write rejected (cfg_ch ≥ NUM_CH or cfg_period = 0)
- pwm_out  out  NUM_CH  registered PWM outputs
- busy  out  NUM_CH  channel in RUN or STOPPING
- done  out  NUM_CH  one-cycle pulse when a channel returns to IDLE

## Operation
- Per-channel state: IDLE, RUN, STOPPING.
- Per-channel active registers: P, D, burst, counter cnt (CNT_W), completed-period counter bc (8 bit).
- Per-channel pending registers plus a pend_valid flag.
- Accepted write, channel IDLE, cfg_en=1:
  - Load active registers directly.
  - Set cnt = phase, or 0 if phase > P; clear bc.
  - Enter RUN.
- Accepted write, channel IDLE, cfg_en=0: no state change; ack only.
- Accepted write, channel RUN or STOPPING, cfg_en=1:
  - Store the values in pending registers and set pend_valid.
  - A later write overwrites earlier pending values (last write wins).
  - A write with cfg_en=1 to a STOPPING channel returns it to RUN.
- Accepted write, channel RUN, cfg_en=0: enter STOPPING; pending registers are unchanged.
- RUN/STOPPING counting: cnt increments each cycle; cnt == P is the wrap point, and the next cnt is 0.
- At the wrap point, in priority order:
  1. STOPPING → IDLE and done pulse.
  2. Otherwise bc+1. If burst≠0 and bc+1 == burst → IDLE and done pulse.
  3. Otherwise, if pend_valid: load pending into active, clear pend_valid, clear bc. Pending phase is ignored; cnt wraps to 0.
- Output: pwm_out register ← (state≠IDLE) && (cnt < D). It lags cnt by exactly one cycle.
- IDLE forces cnt=0, bc=0. pwm_out goes low on the cycle after leaving RUN.
- Arithmetic: cnt < D is an unsigned CNT_W-bit compare. bc saturates at 255 when burst=0.
- Rejected writes change no channel state.
- Simultaneous wrap and write to the same channel: the wrap actions use the registers as they were before the write. The write then lands in pending, so it applies at the next wrap.
- Reset: all channels IDLE. cnt, bc, active/pending registers and pend_valid = 0. Outputs pwm_out, busy, done, cfg_ack, cfg_err = 0.
- Reset mid-operation: outputs go low immediately (asynchronous); no done pulse.

## Timing
- Edge E0 samples cfg_we.
  - After E0: cfg_ack or cfg_err high for one cycle.
  - For a start: busy=1 and cnt=phase after E0.
  - pwm_out reflects (phase < D) after E1.
- Period exactly P+1 cycles. With phase=0, the first high edge is at E1, duty D cycles.
- Done timing:
  - Edge where cnt==P and stop/burst-end applies: state IDLE, busy=0, done=1 for that cycle.
  - pwm_out shows the last compare (P<D) for that cycle, then 0.
- Pending update: first cycle of the new period (cnt=0) is compared against the new D, so there is no partial period.
- Back-to-back writes on consecutive cycles are all accepted; there is no back-pressure.

## Test plan
- Basic PWM: write ch0 P=49, D=25, phase 0, burst 0 → 1 MHz, 25 high/25 low, busy stays 1, cfg_ack one cycle after E0.
- Burst: ch1 P=9, D=3, burst=4 → exactly 4 pulses of 3 cycles. done pulse on the edge after the 40th counting cycle, then pwm_out low and busy 0.
- Glitch-free update: ch0 running P=49/D=25; write D=10 mid-period → current period stays 25 high, next period 10 high, no runt pulse.
- Graceful stop and phase: ch2 P=19, D=10, phase=15 → first period 0 high cycles then wrap; cfg_en=0 mid-period → finishes the period, done pulse, output low.
- Edge duties and errors: D=0 → constant low; D=P+1 → constant high. cfg_ch=NUM_CH or cfg_period=0 → cfg_err, no channel change.
- Reset mid-burst: rst_n low during ch1 burst → all outputs 0 asynchronously, no done. After release, channels IDLE until rewritten.
